// File: rtl/kb_event_ctrl.sv
// kb_event_ctrl: PS/2 Set-2 prefix parser, held-key tracker for two
// players, and a small FWFT FIFO of new key-press events.
module kb_event_ctrl #(
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       rd_en,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       overflow,
  output logic [7:0] p1_keys,
  output logic [7:0] p2_keys,
  output logic       any_key
);

  localparam int N = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, EXT, BRK, EXT_BRK, SKIP
  } state_t;

  state_t             state;
  logic [2:0]         skip;
  logic               mk, brk, ext;
  logic [15:0]        hit, held;
  logic [8:0]         mem [N];
  logic [FIFO_AW-1:0] rptr, wptr;
  logic [FIFO_AW:0]   cnt;
  logic               wr_req, wr_ok, rd_ok;

  // classify the incoming byte as make/break from the current prefix state
  always_comb begin
    mk  = 1'b0;
    brk = 1'b0;
    ext = 1'b0;
    if (rx_done_tick) begin
      case (state)
        IDLE: mk = !(rx_data inside
                 {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA});
        EXT: begin
          mk  = (rx_data != 8'hF0);
          ext = 1'b1;
        end
        BRK: brk = 1'b1;
        EXT_BRK: begin
          brk = 1'b1;
          ext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // map {ext, code} onto the 16 tracked key positions
  always_comb begin
    hit = '0;
    case ({ext, rx_data})
      9'h01D: hit[0]  = 1'b1;
      9'h01C: hit[1]  = 1'b1;
      9'h01B: hit[2]  = 1'b1;
      9'h023: hit[3]  = 1'b1;
      9'h03B: hit[4]  = 1'b1;
      9'h042: hit[5]  = 1'b1;
      9'h04B: hit[6]  = 1'b1;
      9'h03C: hit[7]  = 1'b1;
      9'h175: hit[8]  = 1'b1;
      9'h16B: hit[9]  = 1'b1;
      9'h172: hit[10] = 1'b1;
      9'h174: hit[11] = 1'b1;
      9'h069: hit[12] = 1'b1;
      9'h072: hit[13] = 1'b1;
      9'h07A: hit[14] = 1'b1;
      9'h06B: hit[15] = 1'b1;
      default: ;
    endcase
  end

  // typematic repeats of an already-held key are not queued
  assign wr_req = mk && ((hit & held) == 16'h0);
  assign rd_ok  = rd_en && (cnt != '0);
  assign wr_ok  = wr_req && ((cnt != DEPTH) || rd_en);

  // prefix state machine and pause-sequence skip counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      skip  <= 3'd0;
    end else if (rx_done_tick) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'hE0) state <= EXT;
          else if (rx_data == 8'hF0) state <= BRK;
          else if (rx_data == 8'hE1) begin
            state <= SKIP;
            skip  <= 3'd7;
          end
        end
        EXT: state <= (rx_data == 8'hF0) ? EXT_BRK : IDLE;
        SKIP: begin
          skip <= skip - 3'd1;
          if (skip <= 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // held-key bitmask
  always_ff @(posedge clk or posedge reset) begin
    if (reset) held <= '0;
    else if (mk) held <= held | hit;
    else if (brk) held <= held & ~hit;
  end

  // event FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) begin
        mem[wptr] <= {ext, rx_data};
        wptr      <= wptr + FIFO_AW'(1);
      end
      if (rd_ok) rptr <= rptr + FIFO_AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // sticky flag for dropped press events
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (wr_req && !wr_ok) overflow <= 1'b1;
  end

  assign {key_ext, key_code} = mem[rptr];
  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == DEPTH);
  assign p1_keys    = held[7:0];
  assign p2_keys    = held[15:8];
  assign any_key    = |held;

endmodule

// File: tb/tb_kb_event_ctrl.sv
// tb_kb_event_ctrl: vector table, reset corner cases and random
// traffic against a queue-based reference model.
module tb_kb_event_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rd_en;
  logic [7:0] key_code;
  logic       key_ext;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow;
  logic [7:0] p1_keys;
  logic [7:0] p2_keys;
  logic       any_key;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kb_event_ctrl #(.FIFO_AW(2)) dut (
    .clk(clk),
    .reset(reset),
    .rx_done_tick(rx_done_tick),
    .rx_data(rx_data),
    .rd_en(rd_en),
    .key_code(key_code),
    .key_ext(key_ext),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .overflow(overflow),
    .p1_keys(p1_keys),
    .p2_keys(p2_keys),
    .any_key(any_key)
  );

  logic [8:0] p1k [8] = '{9'h01D, 9'h01C, 9'h01B, 9'h023,
                          9'h03B, 9'h042, 9'h04B, 9'h03C};
  logic [8:0] p2k [8] = '{9'h175, 9'h16B, 9'h172, 9'h174,
                          9'h069, 9'h072, 9'h07A, 9'h06B};

  // reference model: prefix flags, skip count, key set, event queue
  bit         m_ext, m_brk, m_ovf;
  int         m_skip;
  bit         held [512];
  logic [8:0] q [$];

  function automatic bit tracked(logic [8:0] k);
    for (int i = 0; i < 8; i++)
      if (p1k[i] == k || p2k[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ext = 0;
    m_brk = 0;
    m_ovf = 0;
    m_skip = 0;
    q.delete();
    for (int i = 0; i < 512; i++) held[i] = 0;
  endtask

  task automatic model_step(bit rx, logic [7:0] d, bit rd);
    bit make, brk, ext, enq, rdok;
    logic [8:0] k;
    make = 0;
    brk = 0;
    ext = 0;
    if (rx) begin
      if (m_skip > 0) m_skip--;
      else if (!m_ext && !m_brk && d == 8'hE1) m_skip = 7;
      else if (!m_ext && !m_brk && d == 8'hE0) m_ext = 1;
      else if (!m_brk && d == 8'hF0) m_brk = 1;
      else if (!m_ext && !m_brk && (d == 8'hAA || d == 8'hFA)) ;
      else begin
        if (m_brk) brk = 1;
        else make = 1;
        ext = m_ext;
        m_ext = 0;
        m_brk = 0;
      end
    end
    k = {ext, d};
    enq = make && !(tracked(k) && held[k]);
    if (make && tracked(k)) held[k] = 1;
    if (brk && tracked(k)) held[k] = 0;
    rdok = rd && q.size() > 0;
    if (enq && !(q.size() < N || rd)) begin
      m_ovf = 1;
      enq = 0;
    end
    if (rdok) void'(q.pop_front());
    if (enq) q.push_back(k);
  endtask

  task automatic check_eq(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_model(string nm);
    logic [7:0] e1, e2;
    for (int i = 0; i < 8; i++) begin
      e1[i] = held[p1k[i]];
      e2[i] = held[p2k[i]];
    end
    check_eq({nm, "/keys"}, {p1_keys, p2_keys, any_key},
             {e1, e2, |{e1, e2}});
    check_eq({nm, "/fifo"}, {fifo_empty, fifo_full, overflow},
             {q.size() == 0, q.size() == N, m_ovf});
    if (q.size() > 0)
      check_eq({nm, "/head"}, {key_ext, key_code}, q[0]);
  endtask

  task automatic cyc(string nm, bit rx, logic [7:0] d, bit rd);
    rx_done_tick = rx;
    rx_data = d;
    rd_en = rd;
    @(posedge clk);
    model_step(rx, d, rd);
    #1;
    check_model(nm);
    @(negedge clk);
    rx_done_tick = 0;
    rd_en = 0;
  endtask

  typedef struct {
    logic       rx;
    logic [7:0] d;
    logic       rd;
    logic [7:0] p1;
    logic [7:0] p2;
    logic       emp;
    logic       full;
    logic       ovf;
    logic [8:0] head;
  } vec_t;

  vec_t tbl [$];

  task automatic add(logic rx, logic [7:0] d, logic rd,
                     logic [7:0] p1, logic [7:0] p2,
                     logic emp, logic full, logic ovf,
                     logic [8:0] head);
    tbl.push_back('{rx, d, rd, p1, p2, emp, full, ovf, head});
  endtask

  logic [7:0] pool [21] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h3B,
                            8'h42, 8'h4B, 8'h3C, 8'h75, 8'h6B,
                            8'h72, 8'h74, 8'h69, 8'h7A, 8'hE0,
                            8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h16,
                            8'h1E};

  initial begin
    reset = 1'b1;
    rx_done_tick = 0;
    rx_data = 0;
    rd_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state",
      {key_code, key_ext, fifo_empty, fifo_full, overflow,
       p1_keys, p2_keys, any_key},
      {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    add(1, 8'h1D, 0, 8'h01, 8'h00, 0, 0, 0, 9'h01D);
    add(1, 8'hF0, 0, 8'h01, 8'h00, 0, 0, 0, 9'h01D);
    add(1, 8'h1D, 0, 8'h00, 8'h00, 0, 0, 0, 9'h01D);
    add(0, 8'h00, 1, 8'h00, 8'h00, 1, 0, 0, 9'h000);
    add(1, 8'hE0, 0, 8'h00, 8'h00, 1, 0, 0, 9'h000);
    add(1, 8'h72, 0, 8'h00, 8'h04, 0, 0, 0, 9'h172);
    add(1, 8'h72, 0, 8'h00, 8'h24, 0, 0, 0, 9'h172);
    add(0, 8'h00, 1, 8'h00, 8'h24, 0, 0, 0, 9'h072);
    add(0, 8'h00, 1, 8'h00, 8'h24, 1, 0, 0, 9'h000);
    add(1, 8'hE0, 0, 8'h00, 8'h24, 1, 0, 0, 9'h000);
    add(1, 8'hF0, 0, 8'h00, 8'h24, 1, 0, 0, 9'h000);
    add(1, 8'h72, 0, 8'h00, 8'h20, 1, 0, 0, 9'h000);
    for (int i = 0; i < 3; i++)
      add(1, 8'h1C, 0, 8'h02, 8'h20, 0, 0, 0, 9'h01C);
    for (int i = 0; i < 2; i++)
      add(1, 8'h16, 0, 8'h02, 8'h20, 0, 0, 0, 9'h01C);
    add(0, 8'h00, 1, 8'h02, 8'h20, 0, 0, 0, 9'h016);
    add(0, 8'h00, 1, 8'h02, 8'h20, 0, 0, 0, 9'h016);
    add(0, 8'h00, 1, 8'h02, 8'h20, 1, 0, 0, 9'h000);
    add(1, 8'hF0, 0, 8'h02, 8'h20, 1, 0, 0, 9'h000);
    add(1, 8'h1C, 0, 8'h00, 8'h20, 1, 0, 0, 9'h000);
    add(1, 8'hF0, 0, 8'h00, 8'h20, 1, 0, 0, 9'h000);
    add(1, 8'h72, 0, 8'h00, 8'h00, 1, 0, 0, 9'h000);
    add(1, 8'h16, 0, 8'h00, 8'h00, 0, 0, 0, 9'h016);
    add(1, 8'h1E, 0, 8'h00, 8'h00, 0, 0, 0, 9'h016);
    add(1, 8'h26, 0, 8'h00, 8'h00, 0, 0, 0, 9'h016);
    add(1, 8'h25, 0, 8'h00, 8'h00, 0, 1, 0, 9'h016);
    add(1, 8'h2E, 0, 8'h00, 8'h00, 0, 1, 1, 9'h016);
    add(1, 8'h36, 0, 8'h00, 8'h00, 0, 1, 1, 9'h016);
    add(0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 1, 9'h01E);
    add(0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 1, 9'h026);
    add(0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 1, 9'h025);
    add(0, 8'h00, 1, 8'h00, 8'h00, 1, 0, 1, 9'h000);
    add(0, 8'h00, 1, 8'h00, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'h16, 0, 8'h00, 8'h00, 0, 0, 1, 9'h016);
    add(1, 8'h1E, 0, 8'h00, 8'h00, 0, 0, 1, 9'h016);
    add(1, 8'h26, 0, 8'h00, 8'h00, 0, 0, 1, 9'h016);
    add(1, 8'h25, 0, 8'h00, 8'h00, 0, 1, 1, 9'h016);
    add(1, 8'h2E, 1, 8'h00, 8'h00, 0, 1, 1, 9'h01E);
    add(0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 1, 9'h026);
    add(0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 1, 9'h025);
    add(0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 1, 9'h02E);
    add(0, 8'h00, 1, 8'h00, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'hE1, 0, 8'h00, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'h14, 0, 8'h00, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'h77, 0, 8'h00, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'hE1, 0, 8'h00, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'hF0, 0, 8'h00, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'h14, 0, 8'h00, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'hF0, 0, 8'h00, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'h77, 0, 8'h00, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'h1D, 0, 8'h01, 8'h00, 0, 0, 1, 9'h01D);
    add(0, 8'h00, 1, 8'h01, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'hAA, 0, 8'h01, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'hFA, 0, 8'h01, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'hE0, 0, 8'h01, 8'h00, 1, 0, 1, 9'h000);
    add(1, 8'h75, 0, 8'h01, 8'h01, 0, 0, 1, 9'h175);

    foreach (tbl[i]) begin
      cyc($sformatf("vec%0d", i), tbl[i].rx, tbl[i].d, tbl[i].rd);
      check_eq($sformatf("vec%0d/out", i),
        {p1_keys, p2_keys, any_key, fifo_empty, fifo_full, overflow},
        {tbl[i].p1, tbl[i].p2, |{tbl[i].p1, tbl[i].p2},
         tbl[i].emp, tbl[i].full, tbl[i].ovf});
      if (!tbl[i].emp)
        check_eq($sformatf("vec%0d/head", i),
                 {key_ext, key_code}, tbl[i].head);
    end

    cyc("pend_e0", 1, 8'hE0, 0);
    cyc("pend_f0", 1, 8'hF0, 0);
    #2 reset = 1'b1;
    #1;
    check_eq("async_reset",
      {key_code, key_ext, fifo_empty, fifo_full, overflow,
       p1_keys, p2_keys, any_key},
      {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cyc("post_rst", 1, 8'h23, 0);
    check_eq("post_rst/out", {p1_keys, fifo_empty, key_ext, key_code},
             {8'h08, 1'b0, 9'h023});

    cyc("fill1", 1, 8'h1E, 0);
    cyc("fill2", 1, 8'h26, 0);
    cyc("fill3", 1, 8'h25, 0);
    cyc("full_rw", 1, 8'h2E, 1);
    check_eq("full_rw/out", {fifo_full, overflow, key_ext, key_code},
             {1'b1, 1'b0, 9'h01E});

    for (int i = 0; i < 3000; i++) begin
      bit rx, rd;
      logic [7:0] d;
      rx = $urandom_range(0, 9) < 7;
      rd = $urandom_range(0, 9) < 3;
      if ($urandom_range(0, 21) == 0) d = 8'($urandom);
      else d = pool[$urandom_range(0, 20)];
      cyc($sformatf("rnd%0d", i), rx, d, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kb_event_ctrl.md
# kb_event_ctrl

Keyboard event sequencer between the PS/2 receiver and the scan-code-to-ASCII lookup. It parses the raw PS/2 Set-2 byte stream (E0 extended prefix, F0 break prefix, E1 pause sequence), tracks the held state of the 16 game-control keys for both players, and queues new key-press events in a small FIFO. The FIFO head feeds the ASCII lookup for menu and name entry. The held-key bitmasks drive the fighter control logic directly.

## Interface
Parameters:
- `FIFO_AW`, default 2: FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `rx_done_tick`  in  1  one-cycle pulse; `rx_data` holds a received byte
- `rx_data`  in  8  received PS/2 byte
- `rd_en`  in  1  pop FIFO head; ignored when empty
- `key_code`  out  8  FIFO head scan code, first-word-fall-through; valid when `fifo_empty`=0
- `key_ext`  out  1  FIFO head was E0-prefixed
- `fifo_empty`  out  1  FIFO holds no entries
- `fifo_full`  out  1  FIFO holds 2**FIFO_AW entries
- `overflow`  out  1  sticky; set when a make event is dropped because the FIFO is full
- `p1_keys`  out  8  held bits, bit0..7 = W 1D, A 1C, S 1B, D 23, J 3B, K 42, L 4B, U 3C (all non-extended)
- `p2_keys`  out  8  held bits, bit0..7 = up E0 75, left E0 6B, down E0 72, right E0 74, KP1 69, KP2 72, KP3 7A, KP4 6B (the KP codes are non-extended)
- `any_key`  out  1  OR of `p1_keys` and `p2_keys`

## Operation
- Prefix FSM advances only on `rx_done_tick`. States: IDLE, EXT, BRK, EXT_BRK, SKIP.
  - IDLE: E0 goes to EXT. F0 goes to BRK. E1 goes to SKIP and loads the skip counter with 7. Any other byte is a make (ext=0) and returns to IDLE.
  - EXT: F0 goes to EXT_BRK. Any other byte is a make (ext=1) and returns to IDLE.
  - BRK: any byte is a break (ext=0) and returns to IDLE.
  - EXT_BRK: any byte is a break (ext=1) and returns to IDLE.
  - SKIP: decrement the counter on each byte. Return to IDLE on the byte that decrements it from 1 to 0. SKIP bytes produce no events.
  - The byte AA (BAT OK) and the byte FA (ACK), received in IDLE, produce no event.
- Matching uses the full pair {ext, code}. E0 72 (down) and 72 (KP2) are distinct keys, as are E0 6B and 6B.
- Make on a tracked key:
  - Sets its held bit.
  - Enqueues {ext, code} only if the bit was previously 0. Typematic repeats are suppressed.
- Make on an untracked key: always enqueues.
- Break on a tracked key: clears its held bit.
- Break on an untracked key: no effect. Breaks are never enqueued.
- FIFO write rules:
  - Write accepted when not full.
  - When full, the write is also accepted if `rd_en`=1 in the same cycle. Read and write occur together and the count is unchanged.
  - A write that is not accepted is dropped and sets `overflow`. `overflow` clears only on `reset`.
- FIFO read rules:
  - A read with `rd_en`=1 while empty is ignored. Pointers do not move and no underflow occurs.
  - Pointers wrap modulo 2**FIFO_AW.
  - Full/empty are derived from an FIFO_AW+1-bit count or from extra pointer MSBs.

## Timing
- Byte accepted at clock edge N (`rx_done_tick`=1): FSM state, held bits and FIFO write all update at edge N.
  - `p1_keys`/`p2_keys`/`any_key` reflect the new state in cycle N+1.
  - `fifo_empty` falls and `key_code`/`key_ext` present the entry in cycle N+1 when the FIFO was empty.
- `rd_en` at edge M: the next entry (or `fifo_empty`=1) is presented in cycle M+1.
- Back-to-back `rx_done_tick` on consecutive cycles is handled with no loss.
- Reset values, asynchronous and mid-sequence included:
  - FSM = IDLE, skip counter = 0, pointers = 0, FIFO storage = 0.
  - `key_code`=00, `key_ext`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0.
  - `p1_keys`=00, `p2_keys`=00, `any_key`=0.
- A prefix pending at reset is discarded. The next byte is parsed from IDLE.

## Test plan
- Byte 1D -> `p1_keys`=01, `any_key`=1, FIFO head {0,1D}. Then bytes F0 1D -> `p1_keys`=00, FIFO still 1 entry.
- Bytes E0 72, then 72 -> `p2_keys`=24 (bit2 down, bit5 KP2). Two FIFO entries, {1,72} then {0,72}. Then E0 F0 72 -> `p2_keys`=20.
- Bytes 1C 1C 1C (typematic repeat), then byte 16 twice -> FIFO holds {0,1C},{0,16},{0,16}. `p1_keys`=02.
- Depth 4: six untracked makes 16 1E 26 25 2E 36 with no reads -> `fifo_full`=1, `overflow`=1, head 16. Four reads yield 16 1E 26 25, then `fifo_empty`=1. A fifth read leaves the state unchanged. Full FIFO with `rd_en` and a make in the same cycle -> count stays 4, `overflow` not newly set.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1D -> no events from the first eight bytes. `p1_keys`=01, FIFO head {0,1D}.
- Bytes E0 F0, assert `reset` mid-cycle, release, then byte 23 -> all outputs at reset values during reset. Afterward, `p1_keys`=08, FIFO head {0,23}, not treated as a break.
